// File: rtl/proc_run_ctrl_pkg.sv
// Shared types and default sizes for the processor load/run/readback sequencer.
package proc_ctrl_pkg;

  localparam int IMEM_AW_DEF = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int REG_ID_W    = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DUMP = 3'd4,
    FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Host-side streams of the sequencer: command, instruction words in, register values out.
interface proc_run_ctrl_if
  import proc_ctrl_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  // All three streams: a beat transfers on a clock edge where valid && ready;
  // the sender holds valid and its payload stable until that edge.
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IMEM_AW:0]    cmd_len;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [REG_ID_W-1:0] out_idx;
  logic                out_last;

  modport master (
    output cmd_valid, cmd_len, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/proc_run_timer.sv
// Loadable down-counter that times the processor RUN window; zero flag ends it.
module proc_run_timer #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/proc_run_ctrl.sv
// Sequencer: load program words into IMEM, run the processor, then stream the register file out.
// Optional RUN_CYCLE_CNT_EN adds the run_cycles counter output.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int IMEM_AW      = IMEM_AW_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int NUM_REGS     = 6,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clock,
  input  logic                reset,
  proc_run_ctrl_if.slave      host,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IMEM_AW-1:0]  addr,
  output logic                wEn,
  output logic [DATA_W-1:0]   wDat,
  output logic                working,
  output logic [REG_ID_W-1:0] rID,
  input  logic [DATA_W-1:0]   rdata,
`ifdef RUN_CYCLE_CNT_EN
  output logic [15:0]         run_cycles,
`endif
  output state_t              dbg_state
);

  localparam int TW = IMEM_AW + 3;
  localparam logic [IMEM_AW:0]    DEPTH    = (IMEM_AW+1)'(2**IMEM_AW);
  localparam logic [REG_ID_W-1:0] LAST_IDX = REG_ID_W'(NUM_REGS - 1);

  state_t                r_state;
  state_t                w_next;
  logic [IMEM_AW:0]      r_len;
  logic [IMEM_AW:0]      r_cnt;
  logic [IMEM_AW-1:0]    r_addr;
  logic [DATA_W-1:0]     r_wdat;
  logic                  r_wen;
  logic                  r_working;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [REG_ID_W-1:0]   r_idx;
  logic [REG_ID_W-1:0]   r_rid;
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_data;
  logic [REG_ID_W-1:0]   r_out_idx;
  logic                  r_out_last;

  logic                  w_cmd_fire;
  logic                  w_cmd_bad;
  logic                  w_beat;
  logic                  w_ld_timer;
  logic                  w_out_fire;
  logic                  w_tmr_zero;
  logic [TW-1:0]         w_tmr_val;

  assign w_tmr_val = TW'(r_len) + TW'(DRAIN_CYCLES) - TW'(1);

  proc_run_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_ld_timer),
    .i_en       (r_state == RUN),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_cmd_fire = 1'b0;
    w_cmd_bad  = 1'b0;
    w_beat     = 1'b0;
    w_ld_timer = 1'b0;
    w_out_fire = 1'b0;
    case (r_state)
      IDLE: begin
        if (host.cmd_valid) begin
          if (host.cmd_len > DEPTH) begin
            w_cmd_bad = 1'b1;
          end else if (host.cmd_len == '0) begin
            w_next = GAP;
          end else begin
            w_next     = LOAD;
            w_cmd_fire = 1'b1;
          end
        end
      end
      // The cycle where cnt reaches len is the one showing the final write.
      LOAD: begin
        if (r_cnt == r_len) begin
          w_next     = RUN;
          w_ld_timer = 1'b1;
        end else if (host.in_valid) begin
          w_beat = 1'b1;
        end
      end
      RUN:  if (w_tmr_zero) w_next = GAP;
      GAP:  w_next = DUMP;
      DUMP: begin
        if (r_out_valid && host.out_ready) begin
          w_out_fire = 1'b1;
          if (r_out_last) w_next = FIN;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdat      <= '0;
      r_wen       <= 1'b0;
      r_working   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_rid       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != IDLE);
      r_err     <= w_cmd_bad;
      r_done    <= (w_next == FIN);
      r_wen     <= w_beat;
      r_working <= (w_next == RUN);
      if (w_cmd_fire) begin
        r_len <= host.cmd_len;
        r_cnt <= '0;
      end
      if (w_beat) begin
        r_addr <= r_cnt[IMEM_AW-1:0];
        r_wdat <= host.in_data;
        r_cnt  <= r_cnt + (IMEM_AW+1)'(1);
      end
      // rID leads out_data by one cycle; a handshake issues the next rID and
      // the following cycle samples it.
      if ((r_state != DUMP) && (w_next == DUMP)) begin
        r_idx       <= '0;
        r_rid       <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (r_state == DUMP) begin
        if (w_out_fire) begin
          r_out_valid <= 1'b0;
          if (!r_out_last) begin
            r_idx <= r_idx + REG_ID_W'(1);
            r_rid <= r_idx + REG_ID_W'(1);
          end
        end else if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= rdata;
          r_out_idx   <= r_idx;
          r_out_last  <= (r_idx == LAST_IDX);
        end
      end
    end
  end

`ifdef RUN_CYCLE_CNT_EN
  logic [15:0] r_run_cycles;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_run_cycles <= '0;
    end else if (w_cmd_fire) begin
      r_run_cycles <= '0;
    end else if (r_working && (r_run_cycles != 16'hFFFF)) begin
      r_run_cycles <= r_run_cycles + 16'd1;
    end
  end

  assign run_cycles = r_run_cycles;
`endif

  assign host.cmd_ready = (r_state == IDLE);
  assign host.in_ready  = (r_state == LOAD) && (r_cnt != r_len);
  assign host.out_valid = r_out_valid;
  assign host.out_data  = r_out_data;
  assign host.out_idx   = r_out_idx;
  assign host.out_last  = r_out_last;

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign addr      = r_addr;
  assign wEn       = r_wen;
  assign wDat      = r_wdat;
  assign working   = r_working;
  assign rID       = r_rid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: random programs against a transaction-level model of load, run length and dump.
// Build with RUN_CYCLE_CNT_EN defined to also cover run_cycles.
module tb_proc_run_ctrl;
  import proc_ctrl_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NR = 6;
  localparam int DR = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  proc_run_ctrl_if #(.IMEM_AW(AW), .DATA_W(DW)) host_if ();

  logic          busy, done, err, wEn, working;
  logic [AW-1:0] addr;
  logic [DW-1:0] wDat, rdata;
  logic [3:0]    rID;
  state_t        dbg_state;
`ifdef RUN_CYCLE_CNT_EN
  logic [15:0]   run_cycles;
`endif

  // Processor register file stand-in: combinational read of rID.
  logic [DW-1:0] regs [16];
  assign rdata = regs[rID];

  proc_run_ctrl #(.IMEM_AW(AW), .DATA_W(DW), .NUM_REGS(NR), .DRAIN_CYCLES(DR)) dut (
    .clock     (clock),
    .reset     (reset),
    .host      (host_if.slave),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .addr      (addr),
    .wEn       (wEn),
    .wDat      (wDat),
    .working   (working),
    .rID       (rID),
    .rdata     (rdata),
`ifdef RUN_CYCLE_CNT_EN
    .run_cycles(run_cycles),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / model state ----------------
  logic [AW+DW-1:0] exp_q[$];   // {addr, data} expected on each wEn cycle
  logic [DW-1:0]    prog_words[$];
  int               cur_len = 0;
  int               run_id  = 0;
  bit               err_ok  = 1'b0;

  int            seen_id = 0;
  int            wen_cnt, work_cnt, dump_cnt, done_cnt, exp_idx, stall_checks;
  bit            stall_hold;
  logic [3:0]    hold_idx;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] got [NR];

  // Compare process: outputs sampled mid-cycle, inputs driven just after posedge.
  always @(negedge clock) begin
    if (reset || (run_id != seen_id)) begin
      seen_id      = run_id;
      wen_cnt      = 0;
      work_cnt     = 0;
      dump_cnt     = 0;
      done_cnt     = 0;
      exp_idx      = 0;
      stall_checks = 0;
      stall_hold   = 1'b0;
    end
    if (!reset) begin
      logic [AW+DW-1:0] e;
      chk("cmd_ready_vs_busy", host_if.cmd_ready, !busy);
      chk("wen_working_excl", wEn & working, 1'b0);
      if (!err_ok) chk("err_quiet", err, 1'b0);
      if (wEn) begin
        wen_cnt++;
        chk("wr_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", addr, e[AW+DW-1:DW]);
          chk("wr_data", wDat, e[DW-1:0]);
        end
      end
      if (working) work_cnt++;
      if (stall_hold) begin
        stall_checks++;
        chk("stall_valid", host_if.out_valid, 1'b1);
        chk("stall_idx", host_if.out_idx, hold_idx);
        chk("stall_data", host_if.out_data, hold_data);
      end
      stall_hold = 1'b0;
      if (host_if.out_valid) begin
        chk("out_idx", host_if.out_idx, exp_idx);
        chk("out_data", host_if.out_data, regs[exp_idx[3:0]]);
        chk("out_last", host_if.out_last, exp_idx == NR - 1);
        if (host_if.out_ready) begin
          if (exp_idx < NR) got[exp_idx] = host_if.out_data;
          dump_cnt++;
          exp_idx++;
        end else begin
          stall_hold = 1'b1;
          hold_idx   = host_if.out_idx;
          hold_data  = host_if.out_data;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_working_cycles", work_cnt, (cur_len == 0) ? 0 : cur_len + DR);
        chk("done_writes", wen_cnt, cur_len);
        chk("done_dump_count", dump_cnt, NR);
        chk("done_wr_queue_empty", exp_q.size(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input int len);
    int guard = 0;
    while (!host_if.cmd_ready && guard < 200) begin
      step();
      guard++;
    end
    chk("cmd_ready_wait", host_if.cmd_ready, 1'b1);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_len   = (AW+1)'(len);
    step();
    host_if.cmd_valid = 1'b0;
  endtask

  // in_mode: 0 = always valid, 1 = 1,0,0,1 pattern, 2 = random
  task automatic load_words(input int len, input int in_mode);
    int nsent = 0;
    int cyc   = 0;
    bit v;
    logic [DW-1:0] d;
    while (nsent < len && cyc < 20000) begin
      case (in_mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (v && host_if.in_ready) begin
        d = (prog_words.size() > 0) ? prog_words.pop_front() : DW'($urandom);
        host_if.in_valid = 1'b1;
        host_if.in_data  = d;
        exp_q.push_back({AW'(nsent), d});
        nsent++;
      end else begin
        host_if.in_valid = 1'b0;
        host_if.in_data  = DW'($urandom);
      end
      step();
      cyc++;
    end
    host_if.in_valid = 1'b0;
    chk("load_all_sent", nsent, len);
  endtask

  // out_mode: 0 = always ready, 1 = 5-cycle stall on idx 2, 2 = random
  task automatic drain_dump(input int out_mode, input bit noise);
    int guard  = 0;
    int stalls = 0;
    if (noise) begin
      host_if.cmd_valid = 1'b1;
      host_if.cmd_len   = (AW+1)'(600);
    end
    while (!done && guard < 3000) begin
      case (out_mode)
        0: host_if.out_ready = 1'b1;
        1: begin
          if (host_if.out_valid && host_if.out_idx == 4'd2 && stalls < 5) begin
            host_if.out_ready = 1'b0;
            stalls++;
          end else begin
            host_if.out_ready = 1'b1;
          end
        end
        default: host_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      guard++;
    end
    host_if.cmd_valid = 1'b0;
    chk("done_seen", done, 1'b1);
    step();
    chk("done_one_cycle", done, 1'b0);
    chk("done_pulse_count", done_cnt, 1);
    chk("idle_after_done", host_if.cmd_ready, 1'b1);
  endtask

  task automatic run_prog(input int len, input int in_mode, input int out_mode, input bit noise);
    run_id++;
    cur_len = len;
    send_cmd(len);
    if (noise) begin
      host_if.cmd_valid = 1'b1;
      host_if.cmd_len   = (AW+1)'(600);
    end
    if (len > 0) load_words(len, in_mode);
    drain_dump(out_mode, noise);
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 16; i++) regs[i] = DW'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] s1_prog [10];
    logic [DW-1:0] s1_regs [NR];
    int k;
    int guard;
    s1_prog = '{32'h10f0001c, 32'h10f1001d, 32'h10f2001e, 32'h10f3001f, 32'h10f40020,
                32'h10f50021, 32'h20010000, 32'h21230000, 32'h32450000, 32'h20100000};
    s1_regs = '{32'h39, 32'h56, 32'hffffffff, 32'h1f, 32'h20, 32'h21};

    host_if.cmd_valid = 1'b0;
    host_if.cmd_len   = '0;
    host_if.in_valid  = 1'b0;
    host_if.in_data   = '0;
    host_if.out_ready = 1'b0;
    rand_regs();

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_cmd_ready", host_if.cmd_ready, 1'b1);
    chk("rst_in_ready", host_if.in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_wen", wEn, 1'b0);
    chk("rst_addr", addr, 0);
    chk("rst_wdat", wDat, 0);
    chk("rst_working", working, 1'b0);
    chk("rst_rid", rID, 0);
    chk("rst_out_valid", host_if.out_valid, 1'b0);
    chk("rst_out_data", host_if.out_data, 0);
    chk("rst_out_idx", host_if.out_idx, 0);
    chk("rst_out_last", host_if.out_last, 1'b0);
    chk("rst_state", dbg_state, IDLE);

    // Reference program: fixed words and known register contents.
    for (int i = 0; i < 10; i++) prog_words.push_back(s1_prog[i]);
    for (int i = 0; i < NR; i++) regs[i] = s1_regs[i];
    run_prog(10, 0, 0, 1'b0);
    chk("s1_working_13", work_cnt, 13);
    chk("s1_writes_10", wen_cnt, 10);
    for (int i = 0; i < NR; i++) chk("s1_dump_literal", got[i], s1_regs[i]);
`ifdef RUN_CYCLE_CNT_EN
    chk("s1_run_cycles", run_cycles, 16'd13);
`endif

    // LOAD bubbles.
    rand_regs();
    run_prog(10, 1, 0, 1'b0);
    chk("bubble_writes_10", wen_cnt, 10);

    // out_ready stall on idx 2, with ignored commands while busy.
    rand_regs();
    run_prog(7, 2, 1, 1'b1);
    chk("stall_cycles_5", stall_checks, 5);

    // Zero length: straight to dump.
    rand_regs();
    run_prog(0, 0, 2, 1'b0);
    chk("zero_no_wen", wen_cnt, 0);
    chk("zero_no_working", work_cnt, 0);

    // Oversize command.
    err_ok            = 1'b1;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_len   = (AW+1)'(513);
    step();
    host_if.cmd_valid = 1'b0;
    chk("ovr_err_pulse", err, 1'b1);
    chk("ovr_busy", busy, 1'b0);
    chk("ovr_cmd_ready", host_if.cmd_ready, 1'b1);
    chk("ovr_state", dbg_state, IDLE);
    step();
    chk("ovr_err_one_cycle", err, 1'b0);
    chk("ovr_busy_after", busy, 1'b0);
    err_ok = 1'b0;

    // Full-depth program: addresses 0..511 without wrap.
    rand_regs();
    run_prog(1 << AW, 2, 2, 1'b0);
    chk("full_depth_writes", wen_cnt, 1 << AW);

    // Randomized programs.
    for (int r = 0; r < 6; r++) begin
      rand_regs();
      run_prog($urandom_range(1, 40), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset on the 5th working cycle, then a normal run.
    run_id++;
    cur_len = 10;
    send_cmd(10);
    load_words(10, 0);
    k = 0;
    guard = 0;
    while (guard < 100) begin
      if (working) k++;
      if (k == 5) break;
      step();
      guard++;
    end
    chk("mid_run_reached_5", k, 5);
    reset = 1'b1;
    exp_q.delete();
    step();
    chk("mid_rst_working", working, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd_ready", host_if.cmd_ready, 1'b1);
    chk("mid_rst_wen", wEn, 1'b0);
    chk("mid_rst_out_valid", host_if.out_valid, 1'b0);
    reset = 1'b0;
    rand_regs();
    run_prog(10, 0, 2, 1'b0);
    chk("post_rst_working_13", work_cnt, 13);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
